// File: rtl/vehicle_pkg.sv
// Shared vehicle definitions: selector codes, gearbox FSM states,
// engine RPM defaults and the kickdown throttle threshold.
package vehicle_pkg;

    // Selector lever position codes.
    typedef enum logic [3:0] {
        SEL_P = 4'd3,
        SEL_R = 4'd6,
        SEL_N = 4'd9,
        SEL_D = 4'd12
    } sel_code_e;

    typedef enum logic [1:0] {
        ST_NEUTRAL = 2'd0,
        ST_HOLD    = 2'd1,
        ST_SHIFT   = 2'd2
    } gbx_state_e;

    localparam int IDLE_RPM_DEF      = 800;
    localparam int REDLINE_DEF       = 8000;
    localparam int NEUTRAL_LIMIT_DEF = 4000;

    // Throttle level that requests a kickdown, and the RPM headroom the
    // lower gear must keep below redline for the kickdown to be allowed.
    localparam int KICKDOWN_ACCEL  = 230;
    localparam int KICKDOWN_MARGIN = 1000;

    // Free-revving RPM gain per throttle step when no gear is engaged.
    localparam int NEUTRAL_ACCEL_GAIN = 20;

    // Collapse the two selector wires into a lever code; D wins over R.
    function automatic sel_code_e sel_decode(input logic drive, input logic rev);
        if (drive)
            return SEL_D;
        else if (rev)
            return SEL_R;
        else
            return SEL_N;
    endfunction

endpackage

// File: rtl/gearbox_rpm_calc.sv
// Combinational in-gear engine RPM:
//   IDLE + max(speed - (gear-1)*STEP, 0)*SLOPE + (accel_en ? accel*2 : 0),
// saturated to REDLINE. Math is carried at least RPM_W+4 bits wide so no
// intermediate term can wrap.
module gearbox_rpm_calc
    import vehicle_pkg::*;
#(
    parameter int GW         = 3,
    parameter int SPEED_W    = 8,
    parameter int RPM_W      = 14,
    parameter int SHIFT_STEP = 30,
    parameter int RPM_SLOPE  = 60,
    parameter int IDLE_RPM   = IDLE_RPM_DEF,
    parameter int REDLINE    = REDLINE_DEF
) (
    input  logic [GW-1:0]      gear,
    input  logic [SPEED_W-1:0] speed,
    input  logic [7:0]         accel,
    input  logic               accel_en,
    output logic [RPM_W-1:0]   rpm
);

    localparam int MW = (RPM_W + 4 > 32) ? RPM_W + 4 : 32;

    logic [MW-1:0] base;
    logic [MW-1:0] over;
    logic [MW-1:0] sum;

    // Speed above the bottom of this gear's band, scaled, plus throttle blip.
    always_comb begin
        base = '0;
        if (gear != '0)
            base = (MW'(gear) - MW'(1)) * MW'(SHIFT_STEP);
        over = (MW'(speed) > base) ? (MW'(speed) - base) : '0;
        sum  = MW'(IDLE_RPM) + over * MW'(RPM_SLOPE)
             + (accel_en ? MW'(accel) * MW'(2) : '0);
        rpm  = (sum > MW'(REDLINE)) ? RPM_W'(REDLINE) : sum[RPM_W-1:0];
    end

endmodule

// File: rtl/gearbox_shift_ctrl.sv
// Automatic transmission controller for NUM_GEARS forward gears.
// NEUTRAL -> HOLD -> SHIFT state machine with hysteresis and a timed
// torque cut per shift, plus a registered engine RPM for the dashboard.
// Optional kickdown on heavy throttle: define GEARBOX_KICKDOWN_EN.
module gearbox_shift_ctrl
    import vehicle_pkg::*;
#(
    parameter int NUM_GEARS     = 6,
    parameter int SPEED_W       = 8,
    parameter int RPM_W         = 14,
    parameter int SHIFT_STEP    = 30,
    parameter int HYST          = 5,
    parameter int SHIFT_TICKS   = 3,
    parameter int RPM_SLOPE     = 60,
    parameter int IDLE_RPM      = IDLE_RPM_DEF,
    parameter int NEUTRAL_LIMIT = NEUTRAL_LIMIT_DEF,
    parameter int REDLINE       = REDLINE_DEF,
    localparam int GW           = $clog2(NUM_GEARS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               engine_on,
    input  logic               tick_speed,
    input  logic               drive_sel,
    input  logic               rev_sel,
    input  logic               low_gear_mode,
    input  logic [GW-1:0]      max_gear_limit,
    input  logic [SPEED_W-1:0] speed,
    input  logic [7:0]         accel,
    output logic [GW-1:0]      gear_num,
    output logic               shifting,
    output logic               torque_cut,
    output logic               shift_up,
    output logic               shift_dn,
    output logic [RPM_W-1:0]   rpm
);

    localparam int MW = (RPM_W + 4 > 32) ? RPM_W + 4 : 32;
    localparam int CW = (SHIFT_TICKS < 2) ? 1 : $clog2(SHIFT_TICKS + 1);

    gbx_state_e     state;
    logic [CW-1:0]  cnt;

    sel_code_e      sel;
    logic           sel_d;
    logic           sel_r;
    logic           abort;
    logic [GW-1:0]  lim_eff;
    logic [GW-1:0]  ceil_g;
    logic           force_dn;
    logic           norm_dn;
    logic           norm_up;
    logic           kick_dn;
    logic           up_ok;
    logic           dn_go;
    logic           up_go;
    logic [MW-1:0]  nsum;
    logic [RPM_W-1:0] rpm_neutral;
    logic [RPM_W-1:0] rpm_drive;

    // Selector decode, gear ceiling and the raw shift conditions.
    always_comb begin
        sel     = sel_decode(drive_sel, rev_sel);
        sel_d   = (sel == SEL_D);
        sel_r   = (sel == SEL_R);
        abort   = !engine_on || !(sel_d || sel_r);

        // A zero limit still allows first gear; clamp to the top gear.
        lim_eff = (max_gear_limit == '0) ? GW'(1) : max_gear_limit;
        if (lim_eff > GW'(NUM_GEARS))
            lim_eff = GW'(NUM_GEARS);
        ceil_g  = low_gear_mode ? lim_eff : GW'(NUM_GEARS);

        force_dn = (gear_num > ceil_g);
        norm_dn  = (gear_num > GW'(1)) &&
                   ((MW'(speed) + MW'(HYST)) <
                    ((MW'(gear_num) - MW'(1)) * MW'(SHIFT_STEP)));
        norm_up  = (gear_num < ceil_g) &&
                   (MW'(speed) >= MW'(gear_num) * MW'(SHIFT_STEP));

        // Every downshift source moves one gear; they only differ in
        // priority over the upshift.
        dn_go = force_dn || kick_dn || norm_dn;
        up_go = !dn_go && norm_up && up_ok;
    end

`ifdef GEARBOX_KICKDOWN_EN
    logic [GW-1:0]    gear_below;
    logic [RPM_W-1:0] rpm_pred;
    logic             kd_accel;

    assign gear_below = (gear_num > GW'(1)) ? (gear_num - GW'(1)) : GW'(1);
    assign kd_accel   = (accel >= 8'(KICKDOWN_ACCEL));

    // RPM the engine would see one gear lower, throttle term excluded.
    gearbox_rpm_calc #(
        .GW         (GW),
        .SPEED_W    (SPEED_W),
        .RPM_W      (RPM_W),
        .SHIFT_STEP (SHIFT_STEP),
        .RPM_SLOPE  (RPM_SLOPE),
        .IDLE_RPM   (IDLE_RPM),
        .REDLINE    (REDLINE)
    ) u_rpm_pred (
        .gear     (gear_below),
        .speed    (speed),
        .accel    (accel),
        .accel_en (1'b0),
        .rpm      (rpm_pred)
    );

    assign kick_dn = kd_accel && (gear_num > GW'(1)) &&
                     (MW'(rpm_pred) < MW'(REDLINE - KICKDOWN_MARGIN));
    // Holding the throttle down keeps the lower gear.
    assign up_ok   = !kd_accel;
`else
    assign kick_dn = 1'b0;
    assign up_ok   = 1'b1;
`endif

    // In-gear RPM for the current gear; throttle is ignored during torque cut.
    gearbox_rpm_calc #(
        .GW         (GW),
        .SPEED_W    (SPEED_W),
        .RPM_W      (RPM_W),
        .SHIFT_STEP (SHIFT_STEP),
        .RPM_SLOPE  (RPM_SLOPE),
        .IDLE_RPM   (IDLE_RPM),
        .REDLINE    (REDLINE)
    ) u_rpm_main (
        .gear     (gear_num),
        .speed    (speed),
        .accel    (accel),
        .accel_en (!torque_cut),
        .rpm      (rpm_drive)
    );

    // Free-revving RPM with the neutral rev limiter.
    always_comb begin
        nsum        = MW'(IDLE_RPM) + MW'(accel) * MW'(NEUTRAL_ACCEL_GAIN);
        rpm_neutral = (nsum > MW'(NEUTRAL_LIMIT)) ? RPM_W'(NEUTRAL_LIMIT)
                                                  : nsum[RPM_W-1:0];
    end

    // Shift sequencer: gear, torque-cut timing and one-clk shift pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_NEUTRAL;
            gear_num   <= GW'(1);
            shifting   <= 1'b0;
            torque_cut <= 1'b0;
            shift_up   <= 1'b0;
            shift_dn   <= 1'b0;
            cnt        <= '0;
        end else begin
            shift_up <= 1'b0;
            shift_dn <= 1'b0;
            if (abort) begin
                // Engine off or lever out of D/R beats any pending tick.
                state      <= ST_NEUTRAL;
                gear_num   <= GW'(1);
                shifting   <= 1'b0;
                torque_cut <= 1'b0;
                cnt        <= '0;
            end else begin
                case (state)
                    ST_NEUTRAL: begin
                        gear_num <= GW'(1);
                        state    <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        // Reverse never shifts; D evaluates once per tick.
                        if (tick_speed && sel_d) begin
                            if (dn_go) begin
                                gear_num   <= gear_num - GW'(1);
                                shift_dn   <= 1'b1;
                                shifting   <= 1'b1;
                                torque_cut <= 1'b1;
                                cnt        <= CW'(SHIFT_TICKS);
                                state      <= ST_SHIFT;
                            end else if (up_go) begin
                                gear_num   <= gear_num + GW'(1);
                                shift_up   <= 1'b1;
                                shifting   <= 1'b1;
                                torque_cut <= 1'b1;
                                cnt        <= CW'(SHIFT_TICKS);
                                state      <= ST_SHIFT;
                            end
                        end
                    end
                    ST_SHIFT: begin
                        // The tick that ends the cut does not also evaluate.
                        if (tick_speed) begin
                            if (cnt <= CW'(1)) begin
                                cnt        <= '0;
                                shifting   <= 1'b0;
                                torque_cut <= 1'b0;
                                state      <= ST_HOLD;
                            end else begin
                                cnt <= cnt - CW'(1);
                            end
                        end
                    end
                    default: begin
                        state    <= ST_NEUTRAL;
                        gear_num <= GW'(1);
                    end
                endcase
            end
        end
    end

    // Registered engine RPM, one clk behind its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rpm <= '0;
        else if (!engine_on)
            rpm <= '0;
        else if (state == ST_NEUTRAL)
            rpm <= rpm_neutral;
        else
            rpm <= rpm_drive;
    end

endmodule

// File: tb/tb_gearbox_shift_ctrl.sv
// Directed bench for gearbox_shift_ctrl: a per-cycle reference model feeds a
// scoreboard queue, plus targeted checks of shift points, torque-cut length,
// forced downshifts, abort and RPM corner values.
`timescale 1ns/1ps
module tb_gearbox_shift_ctrl;

    localparam int NG = 6;
    localparam int GW = $clog2(NG + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          engine_on;
    logic          tick_speed;
    logic          drive_sel;
    logic          rev_sel;
    logic          low_gear_mode;
    logic [GW-1:0] max_gear_limit;
    logic [7:0]    speed;
    logic [7:0]    accel;
    logic [GW-1:0] gear_num;
    logic          shifting;
    logic          torque_cut;
    logic          shift_up;
    logic          shift_dn;
    logic [13:0]   rpm;

    gearbox_shift_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .engine_on      (engine_on),
        .tick_speed     (tick_speed),
        .drive_sel      (drive_sel),
        .rev_sel        (rev_sel),
        .low_gear_mode  (low_gear_mode),
        .max_gear_limit (max_gear_limit),
        .speed          (speed),
        .accel          (accel),
        .gear_num       (gear_num),
        .shifting       (shifting),
        .torque_cut     (torque_cut),
        .shift_up       (shift_up),
        .shift_dn       (shift_dn),
        .rpm            (rpm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [GW-1:0] gear;
        logic          sh;
        logic          tc;
        logic          up;
        logic          dn;
        logic [13:0]   rpm;
    } obs_t;

    obs_t sb[$];
    int total = 0;
    int bad   = 0;

    // Reference model state: 0 neutral, 1 hold, 2 shift.
    int m_st   = 0;
    int m_gear = 1;
    int m_cnt  = 0;
    bit m_sh   = 0;

    int seen_up[$];
    int seen_dn[$];
    int dn_tick[$];
    int cut_ticks = 0;
    int tick_no   = 0;

    function automatic int sat(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    function automatic int drive_rpm(input int g, input int spd, input int acc, input bit with_acc);
        int over;
        over = spd - (g - 1) * 30;
        if (over < 0) over = 0;
        return sat(800 + over * 60 + (with_acc ? acc * 2 : 0), 8000);
    endfunction

    task automatic chk(input string tag, input int got, input int want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Advance the model by one clk using the inputs about to be sampled.
    task automatic model_push();
        obs_t e;
        int   lim;
        bit   up, dn, kd_hot;
        up = 0; dn = 0; kd_hot = 0;
        if (!engine_on)   e.rpm = 14'(0);
        else if (m_st == 0) e.rpm = 14'(sat(800 + int'(accel) * 20, 4000));
        else              e.rpm = 14'(drive_rpm(m_gear, int'(speed), int'(accel), !m_sh));

        if (!engine_on || !(drive_sel || rev_sel)) begin
            m_st = 0; m_gear = 1; m_sh = 0; m_cnt = 0;
        end else if (m_st == 0) begin
            m_st = 1; m_gear = 1;
        end else if (m_st == 1) begin
            if (tick_speed && drive_sel) begin
                lim = (max_gear_limit == 0) ? 1 : int'(max_gear_limit);
                if (lim > NG) lim = NG;
                if (!low_gear_mode) lim = NG;
`ifdef GEARBOX_KICKDOWN_EN
                kd_hot = (accel >= 8'd230);
`endif
                if (m_gear > lim) dn = 1;
                else if (kd_hot && m_gear > 1 && drive_rpm(m_gear - 1, int'(speed), 0, 0) < 7000) dn = 1;
                else if (m_gear > 1 && int'(speed) + 5 < (m_gear - 1) * 30) dn = 1;
                else if (m_gear < lim && int'(speed) >= m_gear * 30 && !kd_hot) up = 1;
                if (up || dn) begin
                    m_gear = up ? m_gear + 1 : m_gear - 1;
                    m_sh = 1; m_cnt = 3; m_st = 2;
                end
            end
        end else begin
            if (tick_speed) begin
                m_cnt--;
                if (m_cnt == 0) begin m_sh = 0; m_st = 1; end
            end
        end
        e.gear = GW'(m_gear);
        e.sh   = m_sh;
        e.tc   = m_sh;
        e.up   = up;
        e.dn   = dn;
        sb.push_back(e);
    endtask

    // One clk: push expectation, clock, pop and compare outputs.
    task automatic cyc(input bit tk);
        obs_t e, o;
        bit   tc_before;
        tick_speed = tk;
        tc_before  = torque_cut;
        model_push();
        @(posedge clk);
        #1;
        if (tk) tick_no++;
        if (tk && tc_before) cut_ticks++;
        o = {gear_num, shifting, torque_cut, shift_up, shift_dn, rpm};
        e = sb.pop_front();
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL cycle gear/sh/tc/up/dn/rpm got=%0d/%b/%b/%b/%b/%0d want=%0d/%b/%b/%b/%b/%0d",
                   o.gear, o.sh, o.tc, o.up, o.dn, o.rpm, e.gear, e.sh, e.tc, e.up, e.dn, e.rpm);
        end
        if (shift_up) seen_up.push_back(int'(speed));
        if (shift_dn) begin
            seen_dn.push_back(int'(speed));
            dn_tick.push_back(tick_no);
        end
        tick_speed = 1'b0;
    endtask

    task automatic tick_at(input int spd);
        speed = 8'(spd);
        cyc(1'b1);
        repeat (3) cyc(1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0);
    endtask

    initial begin
        rst = 1'b1; engine_on = 1'b0; tick_speed = 1'b0; drive_sel = 1'b0;
        rev_sel = 1'b0; low_gear_mode = 1'b0; max_gear_limit = '0;
        speed = '0; accel = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gear", int'(gear_num), 1);
        chk("rst_rpm", int'(rpm), 0);
        chk("rst_shifting", int'(shifting), 0);
        chk("rst_torque_cut", int'(torque_cut), 0);
        chk("rst_pulses", int'({shift_up, shift_dn}), 0);
        rst = 1'b0;
        idle(2);

        // Upshift ramp 0..95 in D.
        engine_on = 1'b1; drive_sel = 1'b1; accel = 8'd100;
        idle(2);
        for (int s = 0; s <= 95; s++) tick_at(s);
        chk("up_count", seen_up.size(), 3);
        if (seen_up.size() == 3) begin
            chk("up_at_30", seen_up[0], 30);
            chk("up_at_60", seen_up[1], 60);
            chk("up_at_90", seen_up[2], 90);
        end
        chk("ramp_gear4", int'(gear_num), 4);
        chk("cut_ticks_3x3", cut_ticks, 9);

        // Hysteresis: oscillate 85..90 in gear 4, then ramp down.
        seen_dn.delete();
        for (int s = 94; s >= 85; s--) tick_at(s);
        for (int r = 0; r < 2; r++) begin
            for (int s = 86; s <= 90; s++) tick_at(s);
            for (int s = 89; s >= 85; s--) tick_at(s);
        end
        chk("no_chatter_dn", seen_dn.size(), 0);
        chk("no_chatter_gear", int'(gear_num), 4);
        for (int s = 84; s >= 0; s--) tick_at(s);
        chk("dn_count", seen_dn.size(), 3);
        if (seen_dn.size() == 3) begin
            chk("dn_at_84", seen_dn[0], 84);
            chk("dn_at_54", seen_dn[1], 54);
            chk("dn_at_24", seen_dn[2], 24);
        end
        chk("ramp_down_gear1", int'(gear_num), 1);

        // Forced downshifts from gear 5 to a ceiling of 2.
        for (int s = 0; s <= 130; s++) tick_at(s);
        chk("gear5_at_130", int'(gear_num), 5);
        seen_dn.delete(); dn_tick.delete();
        low_gear_mode = 1'b1; max_gear_limit = GW'(2);
        repeat (14) tick_at(130);
        chk("forced_dn_count", seen_dn.size(), 3);
        chk("forced_gear2", int'(gear_num), 2);
        if (dn_tick.size() == 3) begin
            // Shift tick, three cut ticks, then the next evaluation tick.
            chk("forced_gap1", dn_tick[1] - dn_tick[0], 4);
            chk("forced_gap2", dn_tick[2] - dn_tick[1], 4);
        end

        // Engine drops mid-shift.
        low_gear_mode = 1'b0;
        tick_at(130);
        chk("mid_shift_active", int'(torque_cut), 1);
        engine_on = 1'b0;
        idle(1);
        chk("abort_gear", int'(gear_num), 1);
        chk("abort_rpm", int'(rpm), 0);
        chk("abort_tc", int'(torque_cut), 0);
        chk("abort_pulses", int'({shift_up, shift_dn}), 0);

        // Neutral rev limiter.
        engine_on = 1'b1; drive_sel = 1'b0; rev_sel = 1'b0; accel = 8'd255;
        idle(2);
        chk("neutral_rpm_4000", int'(rpm), 4000);

        // Gear 1, speed 20, no throttle.
        drive_sel = 1'b1; accel = 8'd0; speed = 8'd20;
        idle(3);
        chk("gear1_rpm_2000", int'(rpm), 2000);

        // Top gear at 250 km/h with full throttle.
        accel = 8'd100;
        for (int s = 20; s <= 250; s++) tick_at(s);
        chk("gear6_at_250", int'(gear_num), 6);
        accel = 8'd255;
        tick_at(250);
        chk("gear6_rpm_7310", int'(rpm), 7310);
        chk("gear6_no_kickdown", int'(gear_num), 6);

        // Reverse at 200 km/h saturates at redline and never shifts.
        drive_sel = 1'b0;
        idle(1);
        rev_sel = 1'b1; speed = 8'd200; accel = 8'd0;
        idle(3);
        chk("rev_rpm_redline", int'(rpm), 8000);
        tick_at(200);
        chk("rev_gear1", int'(gear_num), 1);

        // Kickdown request in gear 4 at 100 km/h.
        rev_sel = 1'b0;
        idle(1);
        drive_sel = 1'b1; accel = 8'd100;
        idle(2);
        for (int s = 0; s <= 100; s++) tick_at(s);
        chk("kd_pre_gear4", int'(gear_num), 4);
        accel = 8'd240;
        tick_at(100);
`ifdef GEARBOX_KICKDOWN_EN
        chk("kickdown_gear", int'(gear_num), 3);
`else
        chk("kickdown_gear", int'(gear_num), 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
